// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding, load-use / branch / HI-LO
// stalls, a multi-cycle MULT/DIV busy scoreboard and a saturating stall-cycle counter.
module pipeline_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 4,
  parameter int DIV_LATENCY    = 32,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_decode,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_decode,
  input  logic                      branch_decode,
  input  logic                      using_HI_LO_decode,
  input  logic [REG_ADDR_WIDTH-1:0] Rs_execute,
  input  logic [REG_ADDR_WIDTH-1:0] Rt_execute,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_execute,
  input  logic                      register_write_execute,
  input  logic                      memory_to_register_execute,
  input  logic                      muldiv_start_execute,
  input  logic                      muldiv_is_div_execute,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_memory,
  input  logic                      register_write_memory,
  input  logic                      memory_to_register_memory,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_writeback,
  input  logic                      register_write_writeback,
  input  logic                      redirect_memory,
  input  logic                      perf_clear,
  output logic                      stall_fetch,
  output logic                      stall_decode,
  output logic                      flush_execute_register,
  output logic                      forward_A_decode,
  output logic                      forward_B_decode,
  output logic [1:0]                forward_A_execute,
  output logic [1:0]                forward_B_execute,
  output logic                      muldiv_busy,
  output logic                      muldiv_overlap_error,
  output logic [PERF_WIDTH-1:0]     stall_cycle_count
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY);

  logic [CNT_W-1:0]      r_busy_cnt;
  logic                  r_overlap_err;
  logic [PERF_WIDTH-1:0] r_stall_cnt;
  logic                  w_load_stall;
  logic                  w_branch_stall;
  logic                  w_muldiv_stall;
  logic                  w_stall;

  // Register $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [REG_ADDR_WIDTH-1:0] src,
                               input logic [REG_ADDR_WIDTH-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src);
    if (register_write_memory && hit(src, write_register_memory))
      return 2'b10;
    else if (register_write_writeback && hit(src, write_register_writeback))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forward_A_execute = fwd_sel(Rs_execute);
    forward_B_execute = fwd_sel(Rt_execute);
    forward_A_decode  = register_write_memory && hit(Rs_decode, write_register_memory);
    forward_B_decode  = register_write_memory && hit(Rt_decode, write_register_memory);
  end

  assign muldiv_busy    = (r_busy_cnt != '0);
  assign w_load_stall   = memory_to_register_execute &&
                          (hit(Rs_decode, write_register_execute) ||
                           hit(Rt_decode, write_register_execute));
  assign w_branch_stall = branch_decode &&
                          ((register_write_execute &&
                            (hit(Rs_decode, write_register_execute) ||
                             hit(Rt_decode, write_register_execute))) ||
                           (memory_to_register_memory &&
                            (hit(Rs_decode, write_register_memory) ||
                             hit(Rt_decode, write_register_memory))));
  // A launch in execute this cycle already blocks HI/LO consumers before busy rises.
  assign w_muldiv_stall = using_HI_LO_decode && (muldiv_busy || muldiv_start_execute);
  assign w_stall        = w_load_stall || w_branch_stall || w_muldiv_stall;

  assign stall_fetch            = w_stall;
  assign stall_decode           = w_stall;
  assign flush_execute_register = w_stall || redirect_memory;
  assign muldiv_overlap_error   = r_overlap_err;
  assign stall_cycle_count      = r_stall_cnt;

  // Busy countdown; a start while occupied is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cnt    <= '0;
      r_overlap_err <= 1'b0;
    end else begin
      if (r_busy_cnt != '0)
        r_busy_cnt <= r_busy_cnt - 1'b1;
      else if (muldiv_start_execute)
        r_busy_cnt <= muldiv_is_div_execute ? DIV_LOAD : MUL_LOAD;
      if (muldiv_start_execute && (r_busy_cnt != '0))
        r_overlap_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_stall_cnt <= '0;
    else if (perf_clear)
      r_stall_cnt <= '0;
    else if (w_stall)
      r_stall_cnt <= sat_inc(r_stall_cnt);
  end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Randomised and directed scoreboard bench for pipeline_hazard_scoreboard against a
// cycle-indexed behavioural model.
module tb_pipeline_hazard_scoreboard;
  localparam int RAW = 5;
  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
  localparam int PW = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [RAW-1:0] Rs_decode = '0, Rt_decode = '0, Rs_execute = '0, Rt_execute = '0;
  logic [RAW-1:0] write_register_execute = '0, write_register_memory = '0, write_register_writeback = '0;
  logic branch_decode = 0, using_HI_LO_decode = 0, register_write_execute = 0;
  logic memory_to_register_execute = 0, muldiv_start_execute = 0, muldiv_is_div_execute = 0;
  logic register_write_memory = 0, memory_to_register_memory = 0, register_write_writeback = 0;
  logic redirect_memory = 0, perf_clear = 0;
  logic stall_fetch, stall_decode, flush_execute_register, forward_A_decode, forward_B_decode;
  logic [1:0] forward_A_execute, forward_B_execute;
  logic muldiv_busy, muldiv_overlap_error;
  logic [PW-1:0] stall_cycle_count;

  pipeline_hazard_scoreboard #(.REG_ADDR_WIDTH(RAW), .MUL_LATENCY(MUL_L),
                               .DIV_LATENCY(DIV_L), .PERF_WIDTH(PW)) dut (
    .clk(clk), .reset_n(reset_n), .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
    .branch_decode(branch_decode), .using_HI_LO_decode(using_HI_LO_decode),
    .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
    .write_register_execute(write_register_execute), .register_write_execute(register_write_execute),
    .memory_to_register_execute(memory_to_register_execute),
    .muldiv_start_execute(muldiv_start_execute), .muldiv_is_div_execute(muldiv_is_div_execute),
    .write_register_memory(write_register_memory), .register_write_memory(register_write_memory),
    .memory_to_register_memory(memory_to_register_memory),
    .write_register_writeback(write_register_writeback),
    .register_write_writeback(register_write_writeback), .redirect_memory(redirect_memory),
    .perf_clear(perf_clear), .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .flush_execute_register(flush_execute_register), .forward_A_decode(forward_A_decode),
    .forward_B_decode(forward_B_decode), .forward_A_execute(forward_A_execute),
    .forward_B_execute(forward_B_execute), .muldiv_busy(muldiv_busy),
    .muldiv_overlap_error(muldiv_overlap_error), .stall_cycle_count(stall_cycle_count));

  always #5 clk = ~clk;

  typedef struct {
    logic stall, flush, fad, fbd, busy, err;
    logic [1:0] fae, fbe;
    int cnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Model state: absolute cycle index, last busy cycle, sticky error, stall total.
  int cyc = 0;
  int busy_end = -1;
  bit m_err = 0;
  int m_cnt = 0;

  function automatic bit dep(input logic [RAW-1:0] s, input logic [RAW-1:0] d);
    return (s != 0) && (s == d);
  endfunction

  function automatic logic [1:0] efwd(input logic [RAW-1:0] s);
    if (register_write_memory && dep(s, write_register_memory)) return 2'b10;
    if (register_write_writeback && dep(s, write_register_writeback)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called once per cycle after inputs are applied: predicts outputs, then advances the model.
  task automatic commit();
    exp_t e;
    bit busy, ld, br, md;
    if (!reset_n) begin
      busy_end = -1;
      m_err = 0;
      m_cnt = 0;
    end
    busy = (cyc <= busy_end);
    ld = memory_to_register_execute &&
         (dep(Rs_decode, write_register_execute) || dep(Rt_decode, write_register_execute));
    br = branch_decode &&
         ((register_write_execute &&
           (dep(Rs_decode, write_register_execute) || dep(Rt_decode, write_register_execute))) ||
          (memory_to_register_memory &&
           (dep(Rs_decode, write_register_memory) || dep(Rt_decode, write_register_memory))));
    md = using_HI_LO_decode && (busy || muldiv_start_execute);
    e.stall = ld || br || md;
    e.flush = e.stall || redirect_memory;
    e.fad = register_write_memory && dep(Rs_decode, write_register_memory);
    e.fbd = register_write_memory && dep(Rt_decode, write_register_memory);
    e.fae = efwd(Rs_execute);
    e.fbe = efwd(Rt_execute);
    e.busy = busy;
    e.err = m_err;
    e.cnt = m_cnt;
    q.push_back(e);
    if (reset_n) begin
      if (muldiv_start_execute) begin
        if (busy) m_err = 1;
        else busy_end = cyc + (muldiv_is_div_execute ? DIV_L : MUL_L);
      end
      if (perf_clear) m_cnt = 0;
      else if (e.stall && m_cnt < PMAX) m_cnt = m_cnt + 1;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_fetch", int'(stall_fetch), int'(e.stall));
        chk("stall_decode", int'(stall_decode), int'(e.stall));
        chk("flush_execute", int'(flush_execute_register), int'(e.flush));
        chk("forward_A_decode", int'(forward_A_decode), int'(e.fad));
        chk("forward_B_decode", int'(forward_B_decode), int'(e.fbd));
        chk("forward_A_execute", int'(forward_A_execute), int'(e.fae));
        chk("forward_B_execute", int'(forward_B_execute), int'(e.fbe));
        chk("muldiv_busy", int'(muldiv_busy), int'(e.busy));
        chk("overlap_error", int'(muldiv_overlap_error), int'(e.err));
        chk("stall_cycle_count", int'(stall_cycle_count), e.cnt);
      end
    end
  end

  task automatic clear_inputs();
    {Rs_decode, Rt_decode, Rs_execute, Rt_execute} = '0;
    {write_register_execute, write_register_memory, write_register_writeback} = '0;
    {branch_decode, using_HI_LO_decode, register_write_execute, memory_to_register_execute} = '0;
    {muldiv_start_execute, muldiv_is_div_execute, register_write_memory} = '0;
    {memory_to_register_memory, register_write_writeback, redirect_memory, perf_clear} = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle(); clear_inputs(); commit();
    end
  endtask

  initial begin : stim
    // Reset state, then release.
    next_cycle(); commit();
    next_cycle(); reset_n = 1'b1; commit();

    // Execute forwarding: memory beats writeback; $0 never forwarded.
    next_cycle(); clear_inputs();
    Rs_execute = 3; Rt_execute = 7; write_register_memory = 3; register_write_memory = 1;
    write_register_writeback = 3; register_write_writeback = 1; commit();
    next_cycle(); Rs_execute = 0; write_register_memory = 0; write_register_writeback = 0;
    Rt_execute = 0; commit();
    next_cycle(); Rt_execute = 9; write_register_writeback = 9; commit();

    // Load-use stall, then destination $0 gives no stall.
    next_cycle(); clear_inputs();
    memory_to_register_execute = 1; write_register_execute = 5; Rt_decode = 5; commit();
    next_cycle(); write_register_execute = 0; Rt_decode = 0; commit();

    // Branch compare against a memory-stage load.
    next_cycle(); clear_inputs();
    branch_decode = 1; Rs_decode = 6; memory_to_register_memory = 1; write_register_memory = 6;
    register_write_memory = 1; commit();
    idle(3);

    // DIV with MFLO waiting in decode, then a MULT overlapped by a second start.
    next_cycle(); clear_inputs(); muldiv_start_execute = 1; muldiv_is_div_execute = 1;
    using_HI_LO_decode = 1; commit();
    for (int i = 0; i < DIV_L + 3; i++) begin
      next_cycle(); clear_inputs(); using_HI_LO_decode = 1; commit();
    end
    next_cycle(); clear_inputs(); muldiv_start_execute = 1; commit();
    next_cycle(); clear_inputs(); muldiv_start_execute = 1; muldiv_is_div_execute = 1; commit();
    idle(MUL_L + 2);

    // Reset mid-DIV with a consumer waiting.
    next_cycle(); clear_inputs(); muldiv_start_execute = 1; muldiv_is_div_execute = 1; commit();
    for (int i = 0; i < 15; i++) begin
      next_cycle(); clear_inputs(); using_HI_LO_decode = 1; commit();
    end
    next_cycle(); reset_n = 1'b0; commit();
    next_cycle(); reset_n = 1'b1; commit();

    // Sustained stall until the counter saturates, then clear while stalling.
    for (int i = 0; i < PMAX + 5; i++) begin
      next_cycle(); clear_inputs();
      memory_to_register_execute = 1; write_register_execute = 4; Rs_decode = 4; commit();
    end
    next_cycle(); perf_clear = 1; commit();
    next_cycle(); perf_clear = 0; commit();

    // Random traffic with small specifier ranges to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      Rs_decode = RAW'($urandom_range(0, 3)); Rt_decode = RAW'($urandom_range(0, 3));
      Rs_execute = RAW'($urandom_range(0, 3)); Rt_execute = RAW'($urandom_range(0, 3));
      write_register_execute = RAW'($urandom_range(0, 3));
      write_register_memory = RAW'($urandom_range(0, 3));
      write_register_writeback = RAW'($urandom_range(0, 3));
      branch_decode = ($urandom_range(0, 2) == 0);
      using_HI_LO_decode = ($urandom_range(0, 2) == 0);
      register_write_execute = $urandom_range(0, 1);
      memory_to_register_execute = ($urandom_range(0, 3) == 0);
      muldiv_start_execute = ($urandom_range(0, 7) == 0);
      muldiv_is_div_execute = ($urandom_range(0, 3) == 0);
      register_write_memory = $urandom_range(0, 1);
      memory_to_register_memory = ($urandom_range(0, 3) == 0);
      register_write_writeback = $urandom_range(0, 1);
      redirect_memory = ($urandom_range(0, 7) == 0);
      perf_clear = ($urandom_range(0, 63) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      commit();
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
